// File: rtl/iic_pkg.sv
// Shared definitions for the I2C EEPROM responder.
//   - FSM state encodings (legacy-compatible 4-bit localparams)
//   - default EEPROM device address and R/W bit values
//   - device-address match helper
package iic_pkg;

  localparam logic [6:0] EEPROM_DEV_ADDR = 7'b1010000;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  localparam int STATE_W = 4;

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] DEV       = 4'd1;
  localparam logic [3:0] ACK_DEV   = 4'd2;
  localparam logic [3:0] AH        = 4'd3;
  localparam logic [3:0] ACK_AH    = 4'd4;
  localparam logic [3:0] AL        = 4'd5;
  localparam logic [3:0] ACK_AL    = 4'd6;
  localparam logic [3:0] WR        = 4'd7;
  localparam logic [3:0] ACK_WR    = 4'd8;
  localparam logic [3:0] RD        = 4'd9;
  localparam logic [3:0] RD_ACK    = 4'd10;
  localparam logic [3:0] WAIT_STOP = 4'd11;

  // True when the upper seven bits of an address byte name this device.
  function automatic logic dev_match(input logic [7:0] addr_byte, input logic [6:0] dev);
    return addr_byte[7:1] == dev;
  endfunction

endpackage

// File: rtl/iic_line_sync.sv
// Brings the asynchronous scl/sda bus lines into the clk domain and decodes
// bus events. Two flops synchronize each line, a third keeps the previous
// synchronized value for edge detection.
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   scl, sda          raw bus lines
//   sda_s             synchronized sda
//   scl_rise/scl_fall one-clk pulses on synchronized scl edges
//   start/stop        one-clk pulses: sda falling/rising while scl is high
module iic_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic scl_p0, scl_p1, scl_p2;
  logic sda_p0, sda_p1, sda_p2;

  // Idle bus is high, so the chains reset to 1 to avoid a spurious edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_p0 <= 1'b1;
      scl_p1 <= 1'b1;
      scl_p2 <= 1'b1;
      sda_p0 <= 1'b1;
      sda_p1 <= 1'b1;
      sda_p2 <= 1'b1;
    end else begin
      // p0 -> p1: metastability settling
      scl_p0 <= scl;
      sda_p0 <= sda;
      scl_p1 <= scl_p0;
      sda_p1 <= sda_p0;
      // p1 -> p2: previous-value copy for edge detection
      scl_p2 <= scl_p1;
      sda_p2 <= sda_p1;
    end
  end

  assign sda_s    = sda_p1;
  assign scl_rise = scl_p1 & ~scl_p2;
  assign scl_fall = ~scl_p1 & scl_p2;
  assign start    = scl_p1 & ~sda_p1 & sda_p2;
  assign stop     = scl_p1 & sda_p1 & ~sda_p2;

endmodule

// File: rtl/iic_eeprom_slave.sv
// I2C responder emulating a serial EEPROM with a two-byte word address.
// Supports byte/page writes, current-address and random reads, and
// sequential reads; the internal pointer wraps modulo the memory depth and
// the upper word-address bits are ignored.
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   scl         bus clock from the master (asynchronous to clk)
//   sda         open-drain bus data: pulled low when driving, else high-Z
//   wr_en       one-clk pulse when a data byte is committed to memory
//   wr_addr     address of the committed byte
//   wr_data     committed byte
//   busy        high while a transfer addressed to this device is active
module iic_eeprom_slave
  import iic_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = EEPROM_DEV_ADDR,
  parameter int         ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scl,
  inout  wire               sda,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic               sda_s, scl_rise, scl_fall, start, stop;
  logic [STATE_W-1:0] state;
  logic [2:0]         bit_cnt;
  logic [7:0]         shreg;
  logic [7:0]         rd_shift;
  logic [7:0]         byte_in;
  logic [ADDR_W-1:0]  ptr;
  logic               rw;
  logic               rd_lead;
  logic               sda_oe;
  logic [7:0]         mem [DEPTH];

  iic_line_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl      (scl),
    .sda      (sda),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  // Open drain: only ever pull low.
  assign sda = sda_oe ? 1'b0 : 1'bz;

  // Byte as it stands once the bit currently on the bus is shifted in.
  assign byte_in = {shreg[6:0], sda_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      rd_shift <= '0;
      ptr      <= '0;
      rw       <= RW_WRITE;
      rd_lead  <= 1'b0;
      sda_oe   <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      wr_en <= 1'b0;
      // Bus conditions override any edge processing in the same clk.
      if (start) begin
        state   <= DEV;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        rd_lead <= 1'b0;
        busy    <= 1'b0;
      end else if (stop) begin
        state   <= IDLE;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        rd_lead <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          DEV, AH, AL, WR: begin
            if (scl_rise) begin
              shreg   <= byte_in;
              bit_cnt <= bit_cnt + 3'd1;
              // bit_cnt wraps to 0 here, ready for the next byte.
              if (bit_cnt == 3'd7) begin
                if (state == DEV) begin
                  if (dev_match(byte_in, DEV_ADDR)) begin
                    rw    <= byte_in[0];
                    busy  <= 1'b1;
                    state <= ACK_DEV;
                  end else begin
                    state <= WAIT_STOP;
                  end
                end else if (state == AH) begin
                  state <= ACK_AH;
                end else if (state == AL) begin
                  ptr   <= byte_in[ADDR_W-1:0];
                  state <= ACK_AL;
                end else begin
                  mem[ptr] <= byte_in;
                  wr_en    <= 1'b1;
                  wr_addr  <= ptr;
                  wr_data  <= byte_in;
                  ptr      <= ptr + 1'b1;
                  state    <= ACK_WR;
                end
              end
            end
          end

          // sda_oe doubles as the ACK phase: the first fall pulls the line
          // low, the second fall releases it and moves on.
          ACK_DEV, ACK_AH, ACK_AL, ACK_WR: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                sda_oe <= 1'b0;
                if (state == ACK_DEV) begin
                  if (rw == RW_READ) begin
                    // The first data bit goes out on the ACK-release fall.
                    sda_oe   <= ~mem[ptr][7];
                    rd_shift <= {mem[ptr][6:0], 1'b0};
                    bit_cnt  <= '0;
                    state    <= RD;
                  end else begin
                    state <= AH;
                  end
                end else if (state == ACK_AH) begin
                  state <= AL;
                end else begin
                  state <= WR;
                end
              end
            end
          end

          RD: begin
            if (scl_fall) begin
              if (rd_lead) begin
                // First bit after a master ACK.
                sda_oe   <= ~rd_shift[7];
                rd_shift <= {rd_shift[6:0], 1'b0};
                rd_lead  <= 1'b0;
              end else if (bit_cnt == 3'd7) begin
                sda_oe  <= 1'b0;
                ptr     <= ptr + 1'b1;
                bit_cnt <= '0;
                state   <= RD_ACK;
              end else begin
                sda_oe   <= ~rd_shift[7];
                rd_shift <= {rd_shift[6:0], 1'b0};
                bit_cnt  <= bit_cnt + 3'd1;
              end
            end
          end

          RD_ACK: begin
            if (scl_rise) begin
              if (!sda_s) begin
                rd_shift <= mem[ptr];
                rd_lead  <= 1'b1;
                bit_cnt  <= '0;
                state    <= RD;
              end else begin
                busy  <= 1'b0;
                state <= WAIT_STOP;
              end
            end
          end

          IDLE, WAIT_STOP: ;

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iic_eeprom_slave.sv
// Bench for iic_eeprom_slave: an I2C master model drives directed
// transactions; expected ACK levels, read bytes and memory writes are queued
// when each transaction is issued and a separate monitor compares them as
// the DUT produces them.
module tb_iic_eeprom_slave;

  localparam int T = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  wire        sda;
  wire        wr_en;
  wire  [3:0] wr_addr;
  wire  [7:0] wr_data;
  wire        busy;

  assign sda = m_sda ? 1'bz : 1'b0;
  pullup (sda);

  always #5 clk = ~clk;

  iic_eeprom_slave #(.DEV_ADDR(7'b1010000), .ADDR_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .scl     (scl),
    .sda     (sda),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int busy_hi_cnt = 0;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t         exp_wr_q[$];
  logic [7:0]  exp_bus_q[$];
  logic [7:0]  obs_bus_q[$];
  string       name_q[$];
  wr_t         mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: memory commits and bus observations are checked against queues.
  always @(negedge clk) begin
    if (busy === 1'b1) busy_hi_cnt++;
    if (wr_en === 1'b1) begin
      if (exp_wr_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_wr_en: got addr 0x%0h data 0x%0h, expected no write", wr_addr, wr_data);
      end else begin
        mon_e = exp_wr_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
        chk("wr_data", 32'(wr_data), 32'(mon_e.data));
      end
    end
    while (obs_bus_q.size() > 0 && exp_bus_q.size() > 0 && name_q.size() > 0)
      chk(name_q.pop_front(), 32'(obs_bus_q.pop_front()), 32'(exp_bus_q.pop_front()));
  end

  task automatic i2c_start();
    m_sda = 1'b1; #T;
    scl = 1'b1;   #T;
    m_sda = 1'b0; #T;
    scl = 1'b0;   #T;
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; #T;
    scl = 1'b1;   #T;
    m_sda = 1'b1; #T;
  endtask

  // Master sends a byte and samples the 9th-clock sda level.
  task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string nm);
    exp_bus_q.push_back({7'b0, exp_ack});
    name_q.push_back(nm);
    for (int i = 7; i >= 0; i--) begin
      m_sda = b[i]; #T;
      scl = 1'b1;   #T;
      scl = 1'b0;   #T;
    end
    m_sda = 1'b1; #T;
    scl = 1'b1;   #(T/2);
    obs_bus_q.push_back({7'b0, sda});
    #(T/2);
    scl = 1'b0;   #T;
  endtask

  // Master clocks in a byte, then ACKs (ack=1) or NACKs it.
  task automatic read_byte(input logic [7:0] exp, input logic ack, input string nm);
    logic [7:0] got;
    got = '0;
    exp_bus_q.push_back(exp);
    name_q.push_back(nm);
    if (!ack) begin
      exp_bus_q.push_back(8'h01);
      name_q.push_back({nm, "_nack_level"});
    end
    m_sda = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      scl = 1'b1; #(T/2);
      got[i] = sda; #(T/2);
      scl = 1'b0; #T;
    end
    obs_bus_q.push_back(got);
    m_sda = ~ack; #T;
    scl = 1'b1;   #(T/2);
    if (!ack) obs_bus_q.push_back({7'b0, sda});
    #(T/2);
    scl = 1'b0;   #T;
    m_sda = 1'b1; #T;
  endtask

  task automatic partial_bits(input logic [3:0] b);
    for (int i = 3; i >= 0; i--) begin
      m_sda = b[i]; #T;
      scl = 1'b1;   #T;
      scl = 1'b0;   #T;
    end
  endtask

  int snap;

  initial begin
    // Reset state
    repeat (5) @(posedge clk);
    #1;
    chk("rst_sda", 32'(sda), 32'h1);
    chk("rst_wr_en", 32'(wr_en), 32'h0);
    chk("rst_wr_addr", 32'(wr_addr), 32'h0);
    chk("rst_wr_data", 32'(wr_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_state", 32'(dut.state), 32'h0);
    rst_n = 1'b1;
    #T;

    // Byte write: 0xA5 -> 0x0003
    i2c_start();
    write_byte(8'hA0, 1'b0, "bw_ack_dev");
    chk("bw_busy_after_dev", 32'(busy), 32'h1);
    write_byte(8'h00, 1'b0, "bw_ack_ah");
    write_byte(8'h03, 1'b0, "bw_ack_al");
    exp_wr_q.push_back('{addr: 4'h3, data: 8'hA5});
    write_byte(8'hA5, 1'b0, "bw_ack_data");
    i2c_stop();
    #T;
    chk("bw_busy_after_stop", 32'(busy), 32'h0);

    // Random read of 0x0003
    i2c_start();
    write_byte(8'hA0, 1'b0, "rr_ack_dev");
    write_byte(8'h00, 1'b0, "rr_ack_ah");
    write_byte(8'h03, 1'b0, "rr_ack_al");
    i2c_start();
    write_byte(8'hA1, 1'b0, "rr_ack_dev_rd");
    read_byte(8'hA5, 1'b0, "rr_data");
    i2c_stop();
    #T;
    chk("rr_state_idle", 32'(dut.state), 32'h0);
    chk("rr_busy", 32'(busy), 32'h0);

    // Address mismatch: no ACKs, no writes, busy never rises
    snap = busy_hi_cnt;
    i2c_start();
    write_byte(8'hA2, 1'b1, "mm_dev");
    write_byte(8'h00, 1'b1, "mm_ah");
    write_byte(8'h05, 1'b1, "mm_al");
    write_byte(8'h77, 1'b1, "mm_data");
    i2c_stop();
    #T;
    chk("mm_busy_cycles", 32'(busy_hi_cnt - snap), 32'h0);

    // Sequential write across the wrap, then sequential read across it
    i2c_start();
    write_byte(8'hA0, 1'b0, "wp_ack_dev");
    write_byte(8'h00, 1'b0, "wp_ack_ah");
    write_byte(8'h0F, 1'b0, "wp_ack_al");
    exp_wr_q.push_back('{addr: 4'hF, data: 8'h11});
    write_byte(8'h11, 1'b0, "wp_ack_d0");
    exp_wr_q.push_back('{addr: 4'h0, data: 8'h22});
    write_byte(8'h22, 1'b0, "wp_ack_d1");
    i2c_stop();
    i2c_start();
    write_byte(8'hA0, 1'b0, "sr_ack_dev");
    write_byte(8'h00, 1'b0, "sr_ack_ah");
    write_byte(8'h0F, 1'b0, "sr_ack_al");
    i2c_start();
    write_byte(8'hA1, 1'b0, "sr_ack_dev_rd");
    read_byte(8'h11, 1'b1, "sr_data0");
    read_byte(8'h22, 1'b0, "sr_data1");
    i2c_stop();
    #T;

    // STOP after 4 data bits: discarded, pointer kept, next write works
    i2c_start();
    write_byte(8'hA0, 1'b0, "ab_ack_dev");
    write_byte(8'h00, 1'b0, "ab_ack_ah");
    write_byte(8'h05, 1'b0, "ab_ack_al");
    partial_bits(4'hA);
    i2c_stop();
    #T;
    chk("ab_ptr_kept", 32'(dut.ptr), 32'h5);
    chk("ab_state_idle", 32'(dut.state), 32'h0);
    i2c_start();
    write_byte(8'hA0, 1'b0, "ab2_ack_dev");
    write_byte(8'h00, 1'b0, "ab2_ack_ah");
    write_byte(8'h06, 1'b0, "ab2_ack_al");
    exp_wr_q.push_back('{addr: 4'h6, data: 8'h3C});
    write_byte(8'h3C, 1'b0, "ab2_ack_data");
    i2c_stop();

    // Reset while the slave pulls sda low for bit 7 of 0x3C
    i2c_start();
    write_byte(8'hA0, 1'b0, "rs_ack_dev");
    write_byte(8'h00, 1'b0, "rs_ack_ah");
    write_byte(8'h06, 1'b0, "rs_ack_al");
    i2c_start();
    write_byte(8'hA1, 1'b0, "rs_ack_dev_rd");
    chk("rs_bit_driven_low", 32'(sda), 32'h0);
    chk("rs_busy_before", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rs_sda_released", 32'(sda), 32'h1);
    chk("rs_busy", 32'(busy), 32'h0);
    chk("rs_mem6_cleared", 32'(dut.mem[6]), 32'h0);
    chk("rs_mem3_cleared", 32'(dut.mem[3]), 32'h0);
    chk("rs_state_idle", 32'(dut.state), 32'h0);
    #T;
    rst_n = 1'b1;
    i2c_stop();

    repeat (10) @(negedge clk);
    #1;
    chk("wr_queue_drained", 32'(exp_wr_q.size()), 32'h0);
    chk("bus_queue_drained", 32'(exp_bus_q.size()), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1);
  end

endmodule

// File: doc/iic_eeprom_slave.md
Name: iic_eeprom_slave

Overview:
- I2C responder that emulates a two-byte-addressed serial EEPROM on the shared scl/sda bus.
- Counterpart of the team's I2C EEPROM master. Used as a bench/on-chip target so the master's write and random-read sequences can be exercised without an external device.
- Oversamples scl/sda on the fast system clock. Decodes START/STOP, device address, 16-bit word address, write data and read requests. Generates ACKs and read data through an open-drain sda.

Parameters:
DEV_ADDR, 7'b1010000, 7-bit device address the block responds to
ADDR_W, 4, internal memory address width; depth = 2**ADDR_W bytes; upper word-address bits ignored

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
scl  input  1  I2C clock from master (asynchronous to clk)
sda  inout  1  I2C data; driven 0 when sda_oe=1, else high-Z (never driven 1)
wr_en  output  1  one-clk pulse when a data byte is committed to memory
wr_addr  output  ADDR_W  address of committed byte
wr_data  output  8  committed byte
busy  output  1  high from a matching device-address ACK until STOP/START/NACK-terminated read

Behaviour:
- Reset values: sda_oe=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, ptr=0, all memory bytes 0, state=IDLE.
- Reset is asynchronous and takes effect mid-transfer; sda is released on the same edge.
- Input conditioning: 2-FF synchronizers on scl and sda, plus one delayed copy of each.
  - scl_rise / scl_fall from the synchronized copies.
  - start = scl_s high and sda_s falling; stop = scl_s high and sda_s rising.
  - Detection latency is 3 clk from the pad edge.
- sda_oe changes only on the clk in which scl_fall is detected, or on start/stop/reset.
- Bits are sampled on scl_rise, MSB first. A 3-bit counter covers bits 0..7, and the shift register is 8 bits.
- States:
  - IDLE: wait for start.
  - DEV: shift 8 bits. On match of bits[7:1]==DEV_ADDR go to ACK_DEV; otherwise go to WAIT_STOP with no ACK.
  - ACK_DEV: on scl_fall assert sda_oe; on the next scl_fall release it.
    - R/W=0: go to AH.
    - R/W=1: load mem[ptr] and go to RD.
  - AH, then ACK_AH: shift and ACK the high address byte, which is discarded.
  - AL, then ACK_AL: shift and ACK the low address byte. ptr <= byte[ADDR_W-1:0] at the 8th rise.
  - WR, then ACK_WR: shift the data byte. At the 8th rise: mem[ptr] <= byte; wr_en pulse; wr_addr = ptr; wr_data = byte; ptr <= ptr+1 (wraps modulo 2**ADDR_W). Then ACK and return to WR for the next byte.
  - RD: on each scl_fall drive sda_oe = ~bit (MSB first, first bit on the ACK-release fall). After the 8th bit, release on the next fall. ptr <= ptr+1 with wrap.
  - RD_ACK: sample sda on scl_rise.
    - 0 (ACK): load mem[ptr] and go to RD.
    - 1 (NACK): go to WAIT_STOP with sda released.
  - WAIT_STOP: ignore everything until start/stop.
- start in any state (repeated START): release sda, clear bit counter, go to DEV. ptr is kept, so a current-address read follows.
- stop in any state: release sda and go to IDLE. A partially shifted byte is discarded, with no write and no ptr change.
- start/stop detection has priority over scl-edge processing in the same clk.
- The block does not depend on the master checking ACKs. ACK timing alone must satisfy a master that does check ACKs.
- busy=1 from ACK_DEV entry on match; 0 on stop, start, NACK or mismatch.

Decomposition:
- Shared package iic_pkg:
  - State encoding localparams (IDLE, DEV, ACK_DEV, AH, ACK_AH, AL, ACK_AL, WR, ACK_WR, RD, RD_ACK, WAIT_STOP).
  - Default EEPROM device address 7'b1010000.
  - R/W bit constants.
- Sub-module iic_line_sync: synchronizers plus scl_rise/scl_fall/start/stop detection. The FSM and memory stay in iic_eeprom_slave.

Test Plan:
- Byte write:
  - Stimulus: START, 0xA0, 0x00, 0x03, 0xA5, STOP.
  - Response: sda low at all four 9th clocks; exactly one wr_en with wr_addr=3, wr_data=0xA5; busy returns to 0 after STOP.
- Random read after the byte write:
  - Stimulus: START, 0xA0, 0x00, 0x03, repeated START, 0xA1, master clocks 8 bits, NACK, STOP.
  - Response: the slave shifts out 0xA5; sda is released at the 9th clock; state is IDLE.
- Address mismatch:
  - Stimulus: START, 0xA2, 0x00, 0x05, 0x77, STOP.
  - Response: sda high at every 9th clock; no wr_en; busy stays 0.
- Sequential read with wrap (ADDR_W=4):
  - Stimulus: write 0x11 to 0x0F and 0x22 to 0x00; then read from 0x0F with the master ACKing the first byte and NACKing the second.
  - Response: read data 0x11, then 0x22.
- Abort cases:
  - STOP after 4 bits of a data byte: no wr_en, ptr unchanged, and a following write succeeds.
  - rst_n low while the slave drives a 0 read bit: sda goes high-Z immediately; busy=0; memory is cleared.
